// File: rtl/esm_pkg.sv
// Shared constants for the ESM feeder: RV32I opcodes, the bubble word and the
// opcode decode table that yields the RegWrite/ALUSrc controls.
package esm_pkg;

  localparam int INSTR_W_DEFAULT = 32;

  localparam logic [31:0] BUBBLE = 32'h0000_0000;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic legal;
    logic reg_write;
    logic alu_src;
  } esm_dec_t;

  function automatic esm_dec_t decode_opcode(input logic [6:0] opc);
    esm_dec_t d;
    d = '{legal: 1'b0, reg_write: 1'b0, alu_src: 1'b0};
    case (opc)
      OPC_OP:     d = '{legal: 1'b1, reg_write: 1'b1, alu_src: 1'b0};
      OPC_OP_IMM: d = '{legal: 1'b1, reg_write: 1'b1, alu_src: 1'b1};
      OPC_LOAD:   d = '{legal: 1'b1, reg_write: 1'b1, alu_src: 1'b1};
      OPC_STORE:  d = '{legal: 1'b1, reg_write: 1'b0, alu_src: 1'b1};
      OPC_BRANCH: d = '{legal: 1'b1, reg_write: 1'b0, alu_src: 1'b0};
      OPC_JAL:    d = '{legal: 1'b1, reg_write: 1'b1, alu_src: 1'b0};
      OPC_JALR:   d = '{legal: 1'b1, reg_write: 1'b1, alu_src: 1'b1};
      OPC_LUI:    d = '{legal: 1'b1, reg_write: 1'b1, alu_src: 1'b1};
      OPC_AUIPC:  d = '{legal: 1'b1, reg_write: 1'b1, alu_src: 1'b1};
      default:    d = '{legal: 1'b0, reg_write: 1'b0, alu_src: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/esm_feed_fifo.sv
// Synchronous FIFO holding instruction words plus their end-of-stream flag.
// Pushes while full and pops while empty are ignored.
module esm_feed_fifo
  import esm_pkg::*;
#(
  parameter int W     = INSTR_W_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       push_last,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic                       head_last,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_en_s;
  logic          pop_en_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign push_en_s = push && !full;
  assign pop_en_s  = pop && !empty;
  assign head_data = mem_r[rd_ptr_r][W-1:0];
  assign head_last = mem_r[rd_ptr_r][W];
  assign count     = count_r;

  // Storage and pointers; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(W+1){1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_en_s) begin
        mem_r[wr_ptr_r] <= {push_last, push_data};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/esm_feeder.sv
// ESM feeder: buffers fetched RV32I words and issues one decoded word per clock.
// Optional macro ESM_FEED_X0_SUPPRESS_EN clears RegWrite for writes to x0.
module esm_feeder
  import esm_pkg::*;
#(
  parameter int Instruction_word_size = INSTR_W_DEFAULT,
  parameter int DEPTH                 = 4,
  parameter int ICNT_W                = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [Instruction_word_size-1:0] in_instr,
  input  logic                             in_last,
  output logic                             in_ready,
  input  logic                             hold,
  output logic [Instruction_word_size-1:0] Instr_out,
  output logic                             RegWrite,
  output logic                             ALUSrc,
  output logic [$clog2(DEPTH):0]           fifo_count,
  output logic [ICNT_W-1:0]                illegal_cnt,
  output logic                             stream_done
);

  localparam int IW = Instruction_word_size;

  logic [IW-1:0] head_data_s;
  logic          head_last_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  esm_dec_t      dec_s;
  logic          reg_write_s;
  logic          zero_s;
  logic          issue_s;
  logic          drop_s;

  // Ready depends only on occupancy so fetch never sees a combinational path from hold.
  assign in_ready = !full_s;
  assign push_s   = in_valid && in_ready;
  assign pop_s    = !empty_s && !hold;

  esm_feed_fifo #(
    .W     (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (in_instr),
    .push_last (in_last),
    .pop       (pop_s),
    .head_data (head_data_s),
    .head_last (head_last_s),
    .count     (fifo_count),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Decode the FIFO head and classify it as issued, dropped (illegal) or a zero bubble.
  always_comb begin
    dec_s       = decode_opcode(head_data_s[6:0]);
    reg_write_s = dec_s.reg_write;
`ifdef ESM_FEED_X0_SUPPRESS_EN
    if (head_data_s[11:7] == 5'd0) begin
      reg_write_s = 1'b0;
    end else begin
      reg_write_s = dec_s.reg_write;
    end
`endif
    zero_s  = (head_data_s == IW'(BUBBLE));
    issue_s = pop_s && dec_s.legal && !zero_s;
    drop_s  = pop_s && !dec_s.legal && !zero_s;
  end

  // Output registers, illegal counter and sticky end-of-stream flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Instr_out   <= IW'(BUBBLE);
      RegWrite    <= 1'b0;
      ALUSrc      <= 1'b0;
      illegal_cnt <= {ICNT_W{1'b0}};
      stream_done <= 1'b0;
    end else begin
      if (issue_s) begin
        Instr_out <= head_data_s;
        RegWrite  <= reg_write_s;
        ALUSrc    <= dec_s.alu_src;
      end else begin
        Instr_out <= IW'(BUBBLE);
        RegWrite  <= 1'b0;
        ALUSrc    <= 1'b0;
      end
      if (drop_s && (illegal_cnt != {ICNT_W{1'b1}})) begin
        illegal_cnt <= illegal_cnt + ICNT_W'(1);
      end else begin
        illegal_cnt <= illegal_cnt;
      end
      if (pop_s && head_last_s) begin
        stream_done <= 1'b1;
      end else begin
        stream_done <= stream_done;
      end
    end
  end

endmodule

// File: tb/tb_esm_feeder.sv
// Self-checking bench for esm_feeder: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_esm_feeder;

  localparam int W      = 32;
  localparam int DEPTH  = 4;
  localparam int ICNT_W = 8;
  localparam int ICNT_MAX = 255;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [W-1:0]      in_instr = 32'h0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              hold = 1'b0;
  logic [W-1:0]      Instr_out;
  logic              RegWrite;
  logic              ALUSrc;
  logic [2:0]        fifo_count;
  logic [ICNT_W-1:0] illegal_cnt;
  logic              stream_done;

  int errors = 0;
  int checks = 0;

  logic [32:0] q[$];
  logic [31:0] m_instr;
  logic        m_rw;
  logic        m_as;
  logic        m_done;
  int          m_ill;

  esm_feeder #(.Instruction_word_size(W), .DEPTH(DEPTH), .ICNT_W(ICNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .hold        (hold),
    .Instr_out   (Instr_out),
    .RegWrite    (RegWrite),
    .ALUSrc      (ALUSrc),
    .fifo_count  (fifo_count),
    .illegal_cnt (illegal_cnt),
    .stream_done (stream_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Returns {legal, reg_write, alu_src} straight from the RV32I opcode table.
  function automatic logic [2:0] ref_decode(input logic [31:0] w);
    logic [2:0] r;
    case (w[6:0])
      7'h33:   r = 3'b110;
      7'h13:   r = 3'b111;
      7'h03:   r = 3'b111;
      7'h23:   r = 3'b101;
      7'h63:   r = 3'b100;
      7'h6F:   r = 3'b110;
      7'h67:   r = 3'b111;
      7'h37:   r = 3'b111;
      7'h17:   r = 3'b111;
      default: r = 3'b000;
    endcase
`ifdef ESM_FEED_X0_SUPPRESS_EN
    if (w[11:7] == 5'd0) r[1] = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [31:0] rand_illegal();
    logic [31:0] w;
    logic [2:0]  d;
    do begin
      w = $urandom();
      d = ref_decode(w);
    end while (d[2] || w == 32'h0);
    return w;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [6:0]  opcs [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    logic [31:0] w;
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'h0;
    if (sel == 1) return rand_illegal();
    w = $urandom();
    w[6:0] = opcs[$urandom_range(0, 8)];
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    m_instr = 32'h0;
    m_rw = 1'b0;
    m_as = 1'b0;
    m_done = 1'b0;
    m_ill = 0;
  endtask

  task automatic check_outputs();
    chk("Instr_out",   Instr_out,   m_instr);
    chk("RegWrite",    RegWrite,    m_rw);
    chk("ALUSrc",      ALUSrc,      m_as);
    chk("fifo_count",  fifo_count,  q.size());
    chk("illegal_cnt", illegal_cnt, m_ill);
    chk("stream_done", stream_done, m_done);
  endtask

  // One clock: drive inputs, check ready, advance the model at the edge, then check outputs.
  task automatic step(input logic v, input logic [31:0] ins, input logic last, input logic h);
    logic        acc;
    logic [32:0] e;
    logic [2:0]  d;
    in_valid = v;
    in_instr = ins;
    in_last  = last;
    hold     = h;
    chk("in_ready", in_ready, (q.size() != DEPTH));
    acc = v && (q.size() < DEPTH);
    @(posedge clk);
    m_instr = 32'h0;
    m_rw = 1'b0;
    m_as = 1'b0;
    if (q.size() > 0 && !h) begin
      e = q.pop_front();
      d = ref_decode(e[31:0]);
      if (e[31:0] != 32'h0) begin
        if (d[2]) begin
          m_instr = e[31:0];
          m_rw = d[1];
          m_as = d[0];
        end else if (m_ill < ICNT_MAX) begin
          m_ill++;
        end
      end
      if (e[32]) m_done = 1'b1;
    end
    if (acc) q.push_back({last, ins});
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  logic [31:0] flow [5] = '{32'h00A00093, 32'h002081B3, 32'h0042A423, 32'h00A2E063, 32'h004004B7};

  initial begin
    model_reset();
    #2 rst = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00A00093;
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("ready_after_reset", in_ready, 1'b1);

    for (int i = 0; i < 4; i++) step(1'b1, flow[i], 1'b0, 1'b0);
    idle(3);

    for (int i = 0; i < 5; i++) step(1'b1, flow[i], 1'b0, 1'b1);
    chk("full_count", fifo_count, 3'd4);
    chk("full_ready", in_ready, 1'b0);
    idle(5);

    step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    step(1'b1, 32'h00000000, 1'b0, 1'b0);
    step(1'b1, 32'h004004B7, 1'b0, 1'b0);
    idle(2);
    chk("illegal_once", illegal_cnt, 8'd1);
    for (int i = 0; i < 300; i++) step(1'b1, rand_illegal(), 1'b0, 1'b0);
    idle(2);
    chk("illegal_sat", illegal_cnt, 8'd255);

    step(1'b1, 32'h0003A283, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("lw_issue_rw", RegWrite, 1'b1);
    chk("done_rise", stream_done, 1'b1);
    idle(3);

    step(1'b1, 32'h00000013, 1'b0, 1'b0);
    step(1'b1, 32'h004000EF, 1'b0, 1'b0);
`ifdef ESM_FEED_X0_SUPPRESS_EN
    chk("x0_suppress_rw", RegWrite, 1'b0);
`else
    chk("x0_plain_rw", RegWrite, 1'b1);
`endif
    chk("x0_as", ALUSrc, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("jal_rw", RegWrite, 1'b1);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 31) == 0,
           $urandom_range(0, 3) == 0);
    end

    for (int i = 0; i < 3; i++) step(1'b1, rand_word(), 1'b1, 1'b1);
    in_valid = 1'b0;
    rst = 1'b0;
    #2;
    model_reset();
    check_outputs();
    rst = 1'b1;
    idle(2);
    for (int i = 0; i < 4; i++) step(1'b1, flow[i], 1'b0, 1'b0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/esm_feeder.md
Name: esm_feeder

Overview:
- Upstream stage of the ESM instruction buffer.
- Accepts RV32I instruction words from fetch over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one instruction per clock to the ESM, together with the decoded RegWrite and ALUSrc controls.
- Inserts all-zero bubbles when it has nothing to issue or is held. The ESM has no backpressure, so this block absorbs all flow control.

Parameters:
- Instruction_word_size, 32, instruction width in bits (opcode field is always bits [6:0]).
- DEPTH, 4, FIFO entries (power of two, 2..16).
- ICNT_W, 8, width of the illegal-instruction counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- in_valid  input  1  fetch presents a word.
- in_instr  input  Instruction_word_size  fetched instruction.
- in_last  input  1  qualifies the final word of the stream.
- in_ready  output  1  block can accept a word this cycle.
- hold  input  1  freeze issue; bubbles are output while high.
- Instr_out  output  Instruction_word_size  instruction to the ESM (0 = bubble).
- RegWrite  output  1  decoded register-write enable for Instr_out.
- ALUSrc  output  1  decoded immediate-operand select for Instr_out.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- illegal_cnt  output  ICNT_W  saturating count of illegal words dropped.
- stream_done  output  1  sticky; the last word has been issued or dropped.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO is emptied.
  - Instr_out = 0, RegWrite = 0, ALUSrc = 0, fifo_count = 0, illegal_cnt = 0, stream_done = 0.
  - in_ready = 1 once rst is released.
  - Reset asserted mid-stream discards all buffered words.
- Accept: a push happens on a rising edge where in_valid && in_ready.
- in_ready = (fifo_count != DEPTH). It is combinational from the count only, with no dependency on pop.
- Pop: on every edge where the FIFO is non-empty and hold = 0, the head is popped and its decoded result is registered onto the outputs.
- Otherwise (empty or hold = 1), the outputs register a bubble: Instr_out = 0, RegWrite = 0, ALUSrc = 0.
- Latency: a word pushed at edge N appears on the outputs after edge N+1 at the earliest. There is no same-cycle bypass.
- Push and pop in the same edge leave fifo_count unchanged. Read and write pointers wrap modulo DEPTH.
- Decode on opcode [6:0]:
  - OP 0110011: RegWrite = 1, ALUSrc = 0.
  - OP-IMM 0010011: 1, 1.
  - LOAD 0000011: 1, 1.
  - STORE 0100011: 0, 1.
  - BRANCH 1100011: 0, 0.
  - JAL 1101111: 1, 0.
  - JALR 1100111: 1, 1.
  - LUI 0110111: 1, 1.
  - AUIPC 0010111: 1, 1.
- Illegal words: a non-zero word with any other opcode is popped normally but issued as a bubble, and illegal_cnt increments, saturating at all-ones.
- All-zero words: issued as a bubble and not counted as illegal.
- in_last: the tail flag is stored per entry. stream_done sets on the edge that pops an entry carrying the flag, whether that entry is issued or dropped. It stays set until reset.
- Pushes after stream_done are still accepted and processed.
- hold is sampled at each edge. Words keep being accepted while hold = 1 until the FIFO is full.

Optional Feature:
- ESM_FEED_X0_SUPPRESS_EN:
  - Defined: RegWrite is forced to 0 when rd (bits [11:7]) is 0, for all RegWrite-producing opcodes. Instr_out is unchanged.
  - Undefined: RegWrite follows the opcode table only.

Decomposition:
- Shared package esm_pkg holds:
  - the opcode localparams (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC);
  - the BUBBLE = 0 constant;
  - the default instruction width.
- One sub-module, esm_feed_fifo: a parameterised synchronous FIFO with the data plus last flag, push/pop, count and full/empty outputs.
- Decode and the output registers live in the top level.

Test Plan:
- Reset check: hold rst low, push addi 00A00093 -> in_ready = 1 after release; outputs 0; fifo_count 0; word not captured during reset.
- Back-to-back flow: push 00A00093, 002081B3, 0042A423, 00A2E063 on consecutive edges, hold = 0 -> issued one per cycle, each 1 cycle after its push, with RegWrite/ALUSrc = 1/1, 1/0, 0/1, 0/0; bubbles afterwards.
- Hold and full: hold = 1, push 5 words with DEPTH = 4 -> in_ready drops after the 4th push, fifo_count = 4, outputs stay bubbles. Release hold -> 4 words issue in order, in_ready returns high after the first pop.
- Illegal handling: push FFFFFFFF, then 00000000, then 004004B7 -> bubble (illegal_cnt = 1), bubble (count still 1), then lui with RegWrite = 1, ALUSrc = 1. Push 300 illegal words -> illegal_cnt saturates at 255.
- End of stream: push lw 0003A283 with in_last = 1 -> stream_done rises on the edge that issues it and stays high through later bubbles. Pull rst low mid-stream -> stream_done, FIFO and counter clear asynchronously.
- With ESM_FEED_X0_SUPPRESS_EN: push 00000013 (addi x0) -> RegWrite = 0, ALUSrc = 1; push 004000EF (jal x1) -> RegWrite = 1.
